mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the core's single picorv32-style memory bus (`mem_valid`/`mem_ready`/`mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_rdata`/`mem_instr`) between `NUM_REQ` requesters, for example the `riscv` core and a debug/DMA port. It sits between the requesters and the memory model or SoC bus. It grants one outstanding transaction at a time, uses round-robin fairness, and registers all downstream outputs. An optional watchdog terminates transactions that never receive `mem_ready`.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, minimum 2.
- `TIMEOUT_CYCLES`, default 255: BUSY cycles without `mem_ready` before the transaction is aborted. Used only when `MEM_ARBITER_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  [NUM_REQ]: request pending; held until the matching `req_ready`.
- `req_instr`  in  [NUM_REQ]: instruction-fetch flag.
- `req_addr`  in  [NUM_REQ][32]: byte address.
- `req_wdata`  in  [NUM_REQ][32]: write data.
- `req_wstrb`  in  [NUM_REQ][4]: byte strobes; 0 means read.
- `req_ready`  out  [NUM_REQ]: one-cycle completion pulse, one-hot or zero.
- `req_rdata`  out  32: read data, shared by all requesters and valid with `req_ready`.
- `req_error`  out  [NUM_REQ]: timeout flag, pulses together with `req_ready`.
- `mem_valid`, `mem_instr`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out: downstream request, all registered.
- `mem_ready`  in  1, `mem_rdata`  in  32: downstream response.
- `grant_id`  out  $clog2(NUM_REQ): index of the current or last granted requester.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:** if any `req_valid` is set, the picker chooses the first set index searching upward from `last+1` modulo NUM_REQ. At that edge the arbiter:
  - latches that requester's instr/addr/wdata/wstrb into the `mem_*` registers,
  - sets `mem_valid`,
  - sets `last` and `grant_id` to the winner,
  - moves to BUSY.
- **BUSY:** `mem_*` outputs are held stable. On the first edge with `mem_ready=1`:
  - latch `mem_rdata` into `req_rdata`,
  - clear `mem_valid`,
  - set `req_ready[grant_id]`,
  - move to RESP.
- **RESP:** one cycle with `req_ready` asserted, then move to IDLE. The requester drops `req_valid` or presents a new request at that edge. Sampling only in IDLE prevents a stale re-grant.
- **Ignored inputs:**
  - `mem_ready` is ignored outside BUSY.
  - `req_*` fields are ignored outside IDLE.
  - A requester that drops `req_valid` while granted does not cancel the transaction; it still completes.
- **Fairness:** `last` resets to NUM_REQ-1, so requester 0 wins the first tie. A continuously requesting port waits at most NUM_REQ-1 transactions.
- **Reset values:**
  - state = IDLE, `last` = NUM_REQ-1,
  - `grant_id` = 0, `mem_valid` = 0, `mem_*` fields = 0,
  - `req_ready` = 0, `req_error` = 0, `req_rdata` = 0.
- **Reset during BUSY or RESP:** the downstream transaction is abandoned and no `req_ready` is issued.

## Timing
- Request sampled in IDLE at edge 0, so `mem_valid` is high from cycle 1.
- `mem_ready` sampled at edge k, so `req_ready` and `req_rdata` are valid in cycle k+1, and the earliest next grant is at edge k+2.
- Minimum transaction is 3 cycles: `mem_ready` asserted in the first BUSY cycle.
- There are no combinational paths from `req_*` or `mem_ready`/`mem_rdata` to any output.

## Configuration
- `MEM_ARBITER_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments on each BUSY cycle without `mem_ready`.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter clears `mem_valid`, sets `req_rdata` to 0, pulses `req_ready` and `req_error` for the granted requester, and moves to RESP.
  - If `mem_ready` arrives in the same cycle as the timeout, `mem_ready` wins and no error is raised.
- Undefined: no counter is built, `req_error` is tied to 0, and `TIMEOUT_CYCLES` is unused.

## Structure
- `mem_arbiter_pkg` holds:
  - the state enum `arb_state_e` (IDLE, BUSY, RESP),
  - the struct `mem_req_t` (instr, addr, wdata, wstrb) used for the latched request,
  - localparam helpers for the index width.
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: `req_valid` vector and `last` index.
  - Outputs: `any` and `winner` index.
  - Reused by future bus arbiters.

## Test plan
- Single read: req0 reads addr 0x100, `mem_ready` asserted in the 3rd BUSY cycle with rdata 0xDEADBEEF. Expect `mem_addr`=0x100 and `mem_wstrb`=0 while BUSY, then one `req_ready[0]` pulse with `req_rdata`=0xDEADBEEF, and `req_valid[0]` not re-granted.
- Simultaneous requests after reset: req0 and req1 both valid with `mem_ready` always 1. Expect grants 0,1,0,1. Each `mem_valid` lasts 1 cycle and consecutive grants are 3 cycles apart.
- Write pass-through: req1 writes 0x12345678 with wstrb 0b0011 to 0x2004. Expect `mem_wdata`, `mem_wstrb` and `mem_addr` to match exactly and stay stable until `mem_ready`.
- Reset during BUSY: assert `reset` mid-transaction. Expect `mem_valid`=0 and `req_ready`=0 immediately without waiting for a clock edge, and requester 0 to win the next tie.
- Timeout (`MEM_ARBITER_TIMEOUT_EN` defined, TIMEOUT_CYCLES=4): `mem_ready` never asserted. Expect `mem_valid` to drop after 4 BUSY cycles, `req_error[g]=1`, `req_ready[g]=1` and `req_rdata`=0. With `mem_ready` on exactly the 4th cycle, expect no error.
- Stray `mem_ready`: `mem_ready` held at 1 while in IDLE with no requests. Expect no `req_ready` pulse and no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-bus arbiter: FSM state encoding, the latched
// downstream request record, and an index-width helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    // Width of an index into n requesters (never below one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// searching upward from last+1, wrapping modulo NUM_REQ.
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    // Candidate index for each search offset, nearest-after-last first.
    logic [NUM_REQ-1:0][IDX_W-1:0] w_cand;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign w_cand[gi] = IDX_W'((32'(last) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
    end

    // Scan from the farthest offset down so the nearest valid request wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[w_cand[k]]) begin
                any    = 1'b1;
                winner = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one picorv32-style memory bus between NUM_REQ
// requesters, one outstanding transaction at a time, registered outputs.
// Optional watchdog: define MEM_ARBITER_TIMEOUT_EN to abort transactions that
// see no mem_ready within TIMEOUT_CYCLES BUSY cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_instr,
    input  logic [NUM_REQ-1:0][31:0]         req_addr,
    input  logic [NUM_REQ-1:0][31:0]         req_wdata,
    input  logic [NUM_REQ-1:0][3:0]          req_wstrb,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [31:0]                      req_rdata,
    output logic [NUM_REQ-1:0]               req_error,
    output logic                             mem_valid,
    output logic                             mem_instr,
    output logic [31:0]                      mem_addr,
    output logic [31:0]                      mem_wdata,
    output logic [3:0]                       mem_wstrb,
    input  logic                             mem_ready,
    input  logic [31:0]                      mem_rdata,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e         r_state;
    mem_req_t           r_mem;
    logic               r_mem_valid;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_grant;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [31:0]        r_rdata;

    logic               w_any;
    logic [IDX_W-1:0]   w_winner;
    mem_req_t           w_sel;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .last      (r_last),
        .any       (w_any),
        .winner    (w_winner)
    );

    assign w_sel = '{instr: req_instr[w_winner],
                     addr:  req_addr[w_winner],
                     wdata: req_wdata[w_winner],
                     wstrb: req_wstrb[w_winner]};

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]   r_to_cnt;
    logic [NUM_REQ-1:0] r_req_error;

    assign req_error = r_req_error;
`else
    assign req_error = '0;
`endif

    // Arbitration FSM: grant in IDLE, hold the bus in BUSY, pulse ready in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem       <= '0;
            r_mem_valid <= 1'b0;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_grant     <= '0;
            r_req_ready <= '0;
            r_rdata     <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_req_error <= '0;
`endif
        end else begin
            r_req_ready <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            r_req_error <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_mem       <= w_sel;
                        r_mem_valid <= 1'b1;
                        r_last      <= w_winner;
                        r_grant     <= w_winner;
                        r_state     <= BUSY;
`ifdef MEM_ARBITER_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        r_rdata              <= mem_rdata;
                        r_mem_valid          <= 1'b0;
                        r_req_ready[r_grant] <= 1'b1;
                        r_state              <= RESP;
                    end
`ifdef MEM_ARBITER_TIMEOUT_EN
                    // mem_ready has priority over a coincident timeout.
                    else if (r_to_cnt == CNT_LAST) begin
                        r_rdata              <= '0;
                        r_mem_valid          <= 1'b0;
                        r_req_ready[r_grant] <= 1'b1;
                        r_req_error[r_grant] <= 1'b1;
                        r_state              <= RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign req_rdata = r_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_instr = r_mem.instr;
    assign mem_addr  = r_mem.addr;
    assign mem_wdata = r_mem.wdata;
    assign mem_wstrb = r_mem.wstrb;
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected completions,
// a latency-programmable memory responder and one task per scenario.
module tb_mem_arbiter;

    localparam logic [31:0] RD_KEY = 32'h5A5A5A5A;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_instr = '0;
    logic [1:0][31:0]  req_addr  = '0;
    logic [1:0][31:0]  req_wdata = '0;
    logic [1:0][3:0]   req_wstrb = '0;
    logic [1:0]        req_ready;
    logic [31:0]       req_rdata;
    logic [1:0]        req_error;
    logic              mem_valid;
    logic              mem_instr;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready = 1'b0;
    logic [31:0]       mem_rdata;
    logic [0:0]        grant_id;

    int checks = 0;
    int failures = 0;

    // Responder controls
    int          lat = 0;
    logic        ready_force = 1'b0;
    logic        use_ovr = 1'b0;
    logic [31:0] ovr = '0;
    int          busy_cnt = 0;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [1:0] mon_rdy;

    mem_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_instr (req_instr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .req_error (req_error),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Memory model: ready on the lat-th BUSY cycle (lat=0: never), or always when forced.
    always @(negedge clk) begin
        if (mem_valid) busy_cnt = busy_cnt + 1;
        else           busy_cnt = 0;
        mem_ready = ready_force || (mem_valid && lat != 0 && busy_cnt == lat);
    end
    assign mem_rdata = use_ovr ? ovr : (mem_addr ^ RD_KEY);

    // Completion monitor: every req_ready pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && req_ready != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready got req_ready=%b want none", req_ready);
            end else begin
                mon_e = exp_q.pop_front();
                mon_rdy = 2'b01 << mon_e.id;
                $display("txn done: id=%0d rdata=%h err=%b", mon_e.id, req_rdata, req_error);
                checks++;
                if (req_ready !== mon_rdy) begin
                    failures++;
                    $display("FAIL ready_onehot got %b want %b", req_ready, mon_rdy);
                end
                checks++;
                if (req_rdata !== mon_e.rdata) begin
                    failures++;
                    $display("FAIL rdata got %h want %h", req_rdata, mon_e.rdata);
                end
                checks++;
                if (req_error !== (mon_e.err ? mon_rdy : 2'b00)) begin
                    failures++;
                    $display("FAIL error_flag got %b want %b", req_error, mon_e.err ? mon_rdy : 2'b00);
                end
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One requester transaction; checks the held downstream fields and BUSY length.
    task automatic do_txn(input int id, input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input int l,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_busy);
        int busy_seen = 0;
        bit done = 0;
        exp_t e;
        @(negedge clk);
        lat = l;
        req_instr[id] = instr;
        req_addr[id]  = addr;
        req_wdata[id] = wdata;
        req_wstrb[id] = wstrb;
        req_valid[id] = 1'b1;
        e.id = id; e.rdata = exp_rdata; e.err = exp_err;
        exp_q.push_back(e);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (mem_valid) begin
                busy_seen++;
                checks++;
                if ({mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {instr, addr, wdata, wstrb}) begin
                    failures++;
                    $display("FAIL busy_fields got %b/%h/%h/%b want %b/%h/%h/%b",
                             mem_instr, mem_addr, mem_wdata, mem_wstrb, instr, addr, wdata, wstrb);
                end
                checks++;
                if (grant_id !== 1'(id)) begin
                    failures++;
                    $display("FAIL busy_grant got %0d want %0d", grant_id, id);
                end
            end
            if (req_ready[id]) begin
                req_valid[id] = 1'b0;
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL txn_timeout got no req_ready want req_ready[%0d]", id);
            req_valid[id] = 1'b0;
        end
        checks++;
        if (busy_seen != exp_busy) begin
            failures++;
            $display("FAIL busy_len got %0d want %0d", busy_seen, exp_busy);
        end
        // The dropped request must not be granted again.
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (mem_valid !== 1'b0) begin
                failures++;
                $display("FAIL stale_regrant got mem_valid=%b want 0", mem_valid);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            failures++;
            $display("FAIL reset_mem got %b/%h/%h/%b want zeros", mem_valid, mem_addr, mem_wdata, mem_wstrb);
        end
        checks++;
        if ({req_ready, req_error, req_rdata, grant_id} !== '0) begin
            failures++;
            $display("FAIL reset_resp got rdy=%b err=%b rdata=%h gid=%0d want zeros",
                     req_ready, req_error, req_rdata, grant_id);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        use_ovr = 1'b1;
        ovr = 32'hDEADBEEF;
        do_txn(0, 1'b0, 32'h100, 32'h0, 4'b0000, 3, 32'hDEADBEEF, 1'b0, 3);
        use_ovr = 1'b0;
    endtask

    task automatic test_write();
        do_txn(1, 1'b0, 32'h2004, 32'h12345678, 4'b0011, 2, 32'h2004 ^ RD_KEY, 1'b0, 2);
    endtask

    task automatic test_simultaneous();
        int exp_ids[4] = '{0, 1, 0, 1};
        int ngr = 0, nrdy = 0, cyc = 0, last_start = 0, vlen = 0;
        logic prev_mv = 1'b0;
        exp_t e;
        pulse_reset();
        ready_force = 1'b1;
        req_addr[0] = 32'h400; req_wstrb[0] = '0; req_instr[0] = 1'b1;
        req_addr[1] = 32'h500; req_wstrb[1] = '0; req_instr[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e.id = exp_ids[i];
            e.rdata = (exp_ids[i] == 0 ? 32'h400 : 32'h500) ^ RD_KEY;
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        req_valid = 2'b11;
        while (nrdy < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_valid) vlen++;
            if (mem_valid && !prev_mv) begin
                checks++;
                if (grant_id !== 1'(exp_ids[ngr])) begin
                    failures++;
                    $display("FAIL rr_order grant %0d got %0d want %0d", ngr, grant_id, exp_ids[ngr]);
                end
                if (ngr > 0) begin
                    checks++;
                    if (cyc - last_start != 3) begin
                        failures++;
                        $display("FAIL grant_spacing got %0d want 3", cyc - last_start);
                    end
                end
                last_start = cyc;
                ngr++;
            end
            if (!mem_valid && prev_mv) begin
                checks++;
                if (vlen != 1) begin
                    failures++;
                    $display("FAIL valid_len got %0d want 1", vlen);
                end
                vlen = 0;
            end
            prev_mv = mem_valid;
            if (req_ready != 2'b00) begin
                nrdy++;
                if (nrdy == 4) req_valid = 2'b00;
            end
        end
        req_valid = 2'b00;
        ready_force = 1'b0;
        checks++;
        if (ngr != 4 || nrdy != 4) begin
            failures++;
            $display("FAIL rr_count got grants=%0d readies=%0d want 4/4", ngr, nrdy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_busy();
        bit seen = 0;
        exp_t e;
        @(negedge clk);
        lat = 0;
        req_addr[0] = 32'h300; req_wstrb[0] = '0;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rb_grant got mem_valid=0 want 1");
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || req_ready !== 2'b00) begin
            failures++;
            $display("FAIL async_reset got mem_valid=%b req_ready=%b want 0/00", mem_valid, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        lat = 1;
        req_addr[1] = 32'h600;
        e.id = 0; e.rdata = 32'h300 ^ RD_KEY; e.err = 1'b0;
        exp_q.push_back(e);
        req_valid = 2'b11;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                seen = 1;
                req_valid = 2'b00;
                checks++;
                if (grant_id !== 1'b0) begin
                    failures++;
                    $display("FAIL post_reset_tie got %0d want 0", grant_id);
                end
            end
        end
        req_valid = 2'b00;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL post_reset_done got no req_ready want req_ready[0]");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stray_ready();
        ready_force = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (mem_valid !== 1'b0 || grant_id !== 1'b0) begin
                failures++;
                $display("FAIL stray_ready got mem_valid=%b gid=%0d want 0/0", mem_valid, grant_id);
            end
        end
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_txn(1, 1'b0, 32'h700, 32'h0, 4'b0000, 0, 32'h0, 1'b1, 4);
        do_txn(1, 1'b0, 32'h704, 32'h0, 4'b0000, 4, 32'h704 ^ RD_KEY, 1'b0, 4);
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_simultaneous();
        test_reset_busy();
        test_stray_ready();
`ifdef MEM_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
